// File: rtl/fft_arith_pkg.sv
// fft_arith_pkg: shared types and constants for the FFT arithmetic blocks.
// Holds the data width, the request/response records used around the
// shared adder, and a small helper for signed overflow detection.
package fft_arith_pkg;

    localparam int DATA_W   = 32;
    // Widest requester tag any arithmetic block needs (up to 8 requesters).
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic                cin;
        logic                sub;
        logic [ID_MAX_W-1:0] id;
    } add_req_t;

    typedef struct packed {
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic                ovf;
        logic [ID_MAX_W-1:0] id;
    } add_rsp_t;

    // Two's complement overflow: operands agree in sign but the result does not.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder32.sv
// adder32: 32-bit carry-lookahead adder built from eight 4-bit lookahead
// blocks. Each block forms its internal carries directly from the block
// carry-in and passes a block generate/propagate carry to the next block.
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < 8; k++) begin : g_blk
        logic [3:0] gg;
        logic [3:0] pp;
        logic       ci;
        logic       c1;
        logic       c2;
        logic       c3;
        logic       bgen;
        logic       bprop;
        logic       co;

        assign gg = g[4*k+3:4*k];
        assign pp = p[4*k+3:4*k];

        if (k == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g_blk[k-1].co;
        end

        assign c1    = gg[0] | (pp[0] & ci);
        assign c2    = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        assign c3    = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & ci);
        assign bgen  = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                     | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign bprop = &pp;
        assign co    = bgen | (bprop & ci);

        assign sum[4*k+3:4*k] = pp ^ {c3, c2, c1, ci};
    end

    assign cout = g_blk[7].co;

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin grant. Scans requesters starting at ptr and
// wrapping, granting the first one found. Purely combinational; the owner
// keeps the pointer register.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Walk ptr, ptr+1, ... mod N and latch onto the first active request.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder32 between N_REQ requesters through a
// round-robin valid/ready arbiter and a two-stage pipeline (operand register,
// result register) with a back-pressurable tagged response port.
// Optional feature macro: ADDER_ARB_SUB_EN enables per-request subtraction
// via req_sub; without it every request is A+B+cin and req_sub is ignored.
module adder_arbiter
    import fft_arith_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ-1:0]        req_cin,
    input  logic [N_REQ-1:0]        req_sub,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_ovf
);

    logic [DATA_W-1:0] a_arr [N_REQ];
    logic [DATA_W-1:0] b_arr [N_REQ];

    logic [ID_W-1:0]   ptr;
    logic [N_REQ-1:0]  gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_any;

    logic              s1_valid;
    logic              s1_load;
    logic              s2_load;
    logic              accept;

    add_req_t          sel_req;
    add_req_t          s1_q;
    add_rsp_t          s2_d;
    add_rsp_t          rsp_q;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              unused_ok;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Each stage advances when its downstream slot is free or is being emptied
    // this cycle, which keeps one-per-cycle throughput under full flow.
    assign s2_load   = !rsp_valid || rsp_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign req_ready = (rst || !s1_load) ? '0 : gnt;
    assign accept    = gnt_any && s1_load && !rst;

    // Select the granted requester and fold subtraction into the operands,
    // so the adder itself only ever adds.
    always_comb begin
        sel_req   = '0;
        sel_req.a = a_arr[gnt_idx];
`ifdef ADDER_ARB_SUB_EN
        sel_req.sub = req_sub[gnt_idx];
        sel_req.b   = sel_req.sub ? ~b_arr[gnt_idx]   : b_arr[gnt_idx];
        sel_req.cin = sel_req.sub ? ~req_cin[gnt_idx] : req_cin[gnt_idx];
`else
        sel_req.sub = 1'b0;
        sel_req.b   = b_arr[gnt_idx];
        sel_req.cin = req_cin[gnt_idx];
`endif
        sel_req.id  = ID_MAX_W'(gnt_idx);
    end

    adder32 u_add (
        .a    (s1_q.a),
        .b    (s1_q.b),
        .cin  (s1_q.cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Assemble the result record from the adder output and the stage-1 tag.
    always_comb begin
        s2_d      = '0;
        s2_d.sum  = add_sum;
        s2_d.cout = add_cout;
        s2_d.ovf  = signed_ovf(s1_q.a[DATA_W-1], s1_q.b[DATA_W-1], add_sum[DATA_W-1]);
        s2_d.id   = s1_q.id;
    end

    // Round-robin pointer moves just past whoever was served; holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Operand register: refills whenever it can move, capturing only real requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
                s1_q <= sel_req;
            end
        end
    end

    // Result register: frozen while the consumer stalls a valid response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else if (s2_load) begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_q <= s2_d;
            end
        end
    end

    assign rsp_sum  = rsp_q.sum;
    assign rsp_cout = rsp_q.cout;
    assign rsp_ovf  = rsp_q.ovf;
    assign rsp_id   = rsp_q.id[ID_W-1:0];

    // The op flag is already folded into the operands and the record tag is
    // sized for the widest configuration, so some bits are intentionally unread.
    assign unused_ok = ^{req_sub, s1_q.sub, rsp_q.id};

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed, scoreboard-checked bench for adder_arbiter
// with four requesters. Expected responses are queued as requests are
// issued; a monitor pops and compares on every response handshake.
module tb_adder_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_cin;
    logic [3:0]   req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    adder_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [31:0] sum, input logic cout, input logic ovf);
        exp_t e;
        e.id   = 2'(id);
        e.sum  = sum;
        e.cout = cout;
        e.ovf  = ovf;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic sub);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i]        = cin;
        req_sub[i]        = sub;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout req%0d: got no accept, expected one within 50 cycles", i);
        req_valid[i] = 1'b0;
    endtask

    task automatic apply_stimulus(input int i, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub,
                                  input logic [31:0] esum, input logic ecout, input logic eovf);
        push_exp(i, esum, ecout, eovf);
        set_req(i, a, b, cin, sub);
        wait_accept(i);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 30 && sb.size() != 0; n++) @(posedge clk);
        #1;
        check_output(tag, 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got id=%0d sum=0x%0h, expected no response", rsp_id, rsp_sum);
            end else begin
                mon_e = sb.pop_front();
                check_output("rsp_id",   64'(rsp_id),   64'(mon_e.id));
                check_output("rsp_sum",  64'(rsp_sum),  64'(mon_e.sum));
                check_output("rsp_cout", 64'(rsp_cout), 64'(mon_e.cout));
                check_output("rsp_ovf",  64'(rsp_ovf),  64'(mon_e.ovf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int     acc_cnt;
        int     k [4];
        logic [3:0] acc;

        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_sub   = '0;

        // Reset state, with every requester asking.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_req_ready", 64'(req_ready), 64'd0);
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_rsp_sum",   64'(rsp_sum),   64'd0);
        check_output("rst_rsp_id",    64'(rsp_id),    64'd0);
        check_output("rst_rsp_cout",  64'(rsp_cout),  64'd0);
        check_output("rst_rsp_ovf",   64'(rsp_ovf),   64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;

        // Single request with latency check.
        apply_stimulus(2, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        @(negedge clk);
        check_output("latency_c1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_output("latency_c2", 64'(rsp_valid), 64'd1);
        drain("drain_single");

        // Carry and overflow corners.
        apply_stimulus(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        apply_stimulus(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        apply_stimulus(3, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
        drain("drain_carry");

        // Round robin: all four requesters valid continuously, three turns each.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++)
                push_exp(i, 32'h1000 * (i + 1) + r + 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            k[i] = 0;
            set_req(i, 32'h1000 * (i + 1), 32'h1, 1'b0, 1'b0);
        end
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            acc = req_ready;
            check_output("rr_grant", 64'(acc), 64'(4'b0001 << (n % 4)));
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    k[i]++;
                    if (k[i] == 3) req_valid[i] = 1'b0;
                    else req_a[i*32 +: 32] = 32'h1000 * (i + 1) + k[i];
                end
            end
        end
        req_valid = '0;
        drain("drain_rr");

        // Stall: response held, stage 1 takes exactly one more request.
        apply_stimulus(0, 32'h0ABC_0000, 32'h0000_1234, 1'b0, 1'b0, 32'h0ABC_1234, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus_setup: begin
            push_exp(1, 32'h1111_1113, 1'b0, 1'b0);
            push_exp(2, 32'h2222_2225, 1'b0, 1'b0);
            push_exp(3, 32'h3333_3337, 1'b0, 1'b0);
            for (int i = 1; i < 4; i++)
                set_req(i, 32'h1111_1111 * i, 32'(i), 1'b1, 1'b0);
        end
        acc_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            acc = req_ready;
            acc_cnt += $countones(acc);
            check_output("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check_output("stall_rsp_sum",   64'(rsp_sum),   64'h0ABC_1234);
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
        end
        check_output("stall_accepts", 64'(acc_cnt), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("release_grant", 64'(req_ready), 64'(4'b0100));
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_accept(3);
        drain("drain_stall");

        // Op select.
`ifdef ADDER_ARB_SUB_EN
        apply_stimulus(1, 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        apply_stimulus(1, 32'd5, 32'd3, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
`else
        apply_stimulus(1, 32'd3, 32'd5, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
`endif
        drain("drain_sub");

        // Reset with both stages full.
        rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd1, 1'b0, 1'b0);
        wait_accept(0);
        set_req(1, 32'd2, 32'd2, 1'b0, 1'b0);
        wait_accept(1);
        rst       = 1'b1;
        rsp_ready = 1'b1;
        set_req(1, 32'd2, 32'd2, 1'b0, 1'b0);
        set_req(2, 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        set_req(3, 32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0);
        @(negedge clk);
        check_output("rst_mid_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        push_exp(1, 32'h0000_0004, 1'b0, 1'b0);
        push_exp(2, 32'h0000_0031, 1'b0, 1'b0);
        push_exp(3, 32'h0000_0010, 1'b1, 1'b0);
        @(negedge clk);
        check_output("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_first_grant",   64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_accept(2);
        wait_accept(3);
        drain("drain_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
